// File: rtl/bp_common_cfg_link_pkg.sv
// Shared definitions for the boot-time config link: register map, sequencer
// states and the write payload carried on the link.
package bp_common_cfg_link_pkg;

  localparam int unsigned cfg_core_id_width_gp = 6;
  localparam int unsigned cfg_addr_width_gp    = 16;
  localparam int unsigned cfg_data_width_gp    = 32;
  localparam int unsigned cfg_num_regs_gp      = 6;

  // Per-tile config register addresses, in the order they are written
  typedef enum logic [2:0] {
    e_cfg_freeze        = 3'd1,
    e_cfg_core_id       = 3'd2,
    e_cfg_icache_lce_id = 3'd3,
    e_cfg_dcache_lce_id = 3'd4,
    e_cfg_cce_id        = 3'd5,
    e_cfg_cce_mode      = 3'd6
  } bp_cfg_reg_e;

  typedef enum logic [1:0] {
    e_seq_idle,
    e_seq_config,
    e_seq_unfreeze,
    e_seq_done
  } bp_cfg_seq_state_e;

  typedef struct packed {
    logic [cfg_core_id_width_gp-1:0] core_id;
    logic [cfg_addr_width_gp-1:0]    addr;
    logic [cfg_data_width_gp-1:0]    data;
  } bp_cfg_link_s;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Clear/up counter with asynchronous reset; clear has priority over up.
// Ports: clk, rst (async, active-high), clear, up, count (registered value).
module bsg_counter_clear_up #(
  parameter int unsigned width_p = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               up,
  output logic [width_p-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (up) begin
      count <= count + width_p'(1);
    end
  end

endmodule

// File: rtl/bp_cfg_sequencer.sv
// Boot-time config sequencer: after start, writes freeze/ID/CCE-mode registers
// to every core tile over a valid/ready link, then clears freeze on every tile.
// Ports: clk_i, reset_i (async, active-high), start_i, cce_mode_i, cfg_ready_i;
//        cfg_v_o, cfg_core_id_o, cfg_addr_o, cfg_data_o, busy_o, done_o (all registered).
module bp_cfg_sequencer
  import bp_common_cfg_link_pkg::*;
#(
  parameter int unsigned num_core_p       = 4,
  parameter int unsigned core_id_width_p  = 6,
  parameter int unsigned cfg_addr_width_p = 16,
  parameter int unsigned cfg_data_width_p = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  input  logic                        cce_mode_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [core_id_width_p-1:0]  cfg_core_id_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int unsigned core_cnt_width = $clog2(num_core_p + 1);
  localparam logic [core_cnt_width-1:0] last_core = core_cnt_width'(num_core_p - 1);
  localparam logic [2:0] last_reg = 3'(cfg_num_regs_gp - 1);

  bp_cfg_seq_state_e state, state_next;
  logic [core_cnt_width-1:0] c, c_next;
  logic [2:0] r, r_next, reg_sel;
  logic c_clear, c_up, r_clear, r_up;
  logic mode, mode_next;
  logic xfer;
  bp_cfg_link_s link_next;

  assign xfer = cfg_v_o & cfg_ready_i;

  bsg_counter_clear_up #(.width_p(core_cnt_width)) core_cnt (
    .clk(clk_i), .rst(reset_i), .clear(c_clear), .up(c_up), .count(c)
  );

  bsg_counter_clear_up #(.width_p(3)) reg_cnt (
    .clk(clk_i), .rst(reset_i), .clear(r_clear), .up(r_up), .count(r)
  );

  // Next-state and counter control
  always_comb begin
    state_next = state;
    mode_next  = mode;
    c_clear    = 1'b0;
    c_up       = 1'b0;
    r_clear    = 1'b0;
    r_up       = 1'b0;
    case (state)
      e_seq_idle, e_seq_done: begin
        if (start_i) begin
          state_next = e_seq_config;
          mode_next  = cce_mode_i;
          c_clear    = 1'b1;
          r_clear    = 1'b1;
        end
      end
      e_seq_config: begin
        if (xfer) begin
          if (r == last_reg) begin
            r_clear = 1'b1;
            if (c == last_core) begin
              c_clear    = 1'b1;
              state_next = e_seq_unfreeze;
            end else begin
              c_up = 1'b1;
            end
          end else begin
            r_up = 1'b1;
          end
        end
      end
      e_seq_unfreeze: begin
        if (xfer) begin
          if (c == last_core) begin
            c_clear    = 1'b1;
            state_next = e_seq_done;
          end else begin
            c_up = 1'b1;
          end
        end
      end
      default: state_next = e_seq_idle;
    endcase
  end

  // Counter values after this edge, so the link payload can be registered
  assign c_next  = c_clear ? '0 : (c_up ? c + core_cnt_width'(1) : c);
  assign r_next  = r_clear ? '0 : (r_up ? r + 3'd1 : r);
  assign reg_sel = r_next + 3'd1;

  // Payload for the write presented in the next cycle
  always_comb begin
    link_next = '0;
    case (state_next)
      e_seq_config: begin
        link_next.core_id = cfg_core_id_width_gp'(c_next);
        link_next.addr    = cfg_addr_width_gp'(reg_sel);
        case (reg_sel)
          e_cfg_freeze:        link_next.data = cfg_data_width_gp'(1);
          e_cfg_core_id:       link_next.data = cfg_data_width_gp'(c_next);
          e_cfg_icache_lce_id: link_next.data = cfg_data_width_gp'({c_next, 1'b0});
          e_cfg_dcache_lce_id: link_next.data = cfg_data_width_gp'({c_next, 1'b1});
          e_cfg_cce_id:        link_next.data = cfg_data_width_gp'(c_next);
          e_cfg_cce_mode:      link_next.data = cfg_data_width_gp'(mode_next);
          default:             link_next.data = '0;
        endcase
      end
      e_seq_unfreeze: begin
        link_next.core_id = cfg_core_id_width_gp'(c_next);
        link_next.addr    = cfg_addr_width_gp'(e_cfg_freeze);
        link_next.data    = '0;
      end
      default: link_next = '0;
    endcase
  end

  // State, latched mode and registered outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= e_seq_idle;
      mode          <= 1'b0;
      cfg_v_o       <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      cfg_core_id_o <= '0;
      cfg_addr_o    <= '0;
      cfg_data_o    <= '0;
    end else begin
      state         <= state_next;
      mode          <= mode_next;
      cfg_v_o       <= (state_next == e_seq_config) || (state_next == e_seq_unfreeze);
      busy_o        <= (state_next == e_seq_config) || (state_next == e_seq_unfreeze);
      done_o        <= (state_next == e_seq_done);
      cfg_core_id_o <= core_id_width_p'(link_next.core_id);
      cfg_addr_o    <= cfg_addr_width_p'(link_next.addr);
      cfg_data_o    <= cfg_data_width_p'(link_next.data);
    end
  end

endmodule

// File: tb/tb_bp_cfg_sequencer.sv
// Self-checking bench for bp_cfg_sequencer: a 2-core and a 1-core instance,
// directed vector table, hand-written corner sequences, and random ready stalls
// checked against a write-list model built from the register map.
module tb_bp_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start  [2];
  logic        mode_s [2];
  logic        ready  [2];
  logic        v      [2];
  logic        busy   [2];
  logic        done   [2];
  logic [5:0]  core   [2];
  logic [15:0] addr   [2];
  logic [31:0] data   [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bp_cfg_sequencer #(.num_core_p(2)) dut2 (
    .clk_i(clk), .reset_i(rst), .start_i(start[0]), .cce_mode_i(mode_s[0]),
    .cfg_v_o(v[0]), .cfg_ready_i(ready[0]), .cfg_core_id_o(core[0]),
    .cfg_addr_o(addr[0]), .cfg_data_o(data[0]), .busy_o(busy[0]), .done_o(done[0])
  );

  bp_cfg_sequencer #(.num_core_p(1)) dut1 (
    .clk_i(clk), .reset_i(rst), .start_i(start[1]), .cce_mode_i(mode_s[1]),
    .cfg_v_o(v[1]), .cfg_ready_i(ready[1]), .cfg_core_id_o(core[1]),
    .cfg_addr_o(addr[1]), .cfg_data_o(data[1]), .busy_o(busy[1]), .done_o(done[1])
  );

  typedef struct {
    logic        rdy;
    logic        v;
    logic [5:0]  core;
    logic [15:0] addr;
    logic [31:0] data;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input int rdy_i, input int v_i, input int core_i,
                              input int addr_i, input int data_i, input int busy_i,
                              input int done_i);
    vec_t t;
    t.rdy  = 1'(rdy_i);
    t.v    = 1'(v_i);
    t.core = 6'(core_i);
    t.addr = 16'(addr_i);
    t.data = 32'(data_i);
    t.busy = 1'(busy_i);
    t.done = 1'(done_i);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Run one full sequence on instance d and compare every write with the
  // list derived from the register map. abort_at >= 0 returns early once that
  // many writes have been accepted.
  task automatic run_seq(input int d, input int ncore, input bit mode, input int stall_pct,
                         input bit flip_mode, input bit poke_start, input bit check_time,
                         input int abort_at);
    int q_core[$];
    int q_addr[$];
    int q_data[$];
    int n, idx, cyc;
    bit fin, stalled, poked;
    logic [5:0]  h_core;
    logic [15:0] h_addr;
    logic [31:0] h_data;
    for (int c = 0; c < ncore; c++) begin
      q_core.push_back(c); q_addr.push_back(1); q_data.push_back(1);
      q_core.push_back(c); q_addr.push_back(2); q_data.push_back(c);
      q_core.push_back(c); q_addr.push_back(3); q_data.push_back(2 * c);
      q_core.push_back(c); q_addr.push_back(4); q_data.push_back(2 * c + 1);
      q_core.push_back(c); q_addr.push_back(5); q_data.push_back(c);
      q_core.push_back(c); q_addr.push_back(6); q_data.push_back(int'(mode));
    end
    for (int c = 0; c < ncore; c++) begin
      q_core.push_back(c); q_addr.push_back(1); q_data.push_back(0);
    end
    n = q_addr.size();
    @(negedge clk);
    mode_s[d] = mode;
    start[d]  = 1'b1;
    ready[d]  = 1'b1;
    idx = 0; fin = 0; stalled = 0; poked = 0;
    h_core = '0; h_addr = '0; h_data = '0;
    for (cyc = 1; cyc <= 4000 && !fin; cyc++) begin
      @(negedge clk);
      start[d] = 1'b0;
      if (poke_start && !poked && idx == 5) begin
        start[d] = 1'b1;
        poked = 1;
      end
      if (flip_mode && cyc == 3) mode_s[d] = ~mode;
      ready[d] = ($urandom_range(99) >= 32'(stall_pct));
      chk("busy", 32'(busy[d]), 32'(idx < n));
      chk("done", 32'(done[d]), 32'(idx == n));
      chk("valid", 32'(v[d]), 32'(idx < n));
      if (abort_at >= 0 && idx == abort_at) return;
      if (idx == n) begin
        if (check_time) chk("done_time", 32'(cyc), 32'(n + 1));
        fin = 1;
      end else begin
        if (stalled) begin
          chk("hold_core", 32'(core[d]), 32'(h_core));
          chk("hold_addr", 32'(addr[d]), 32'(h_addr));
          chk("hold_data", data[d], h_data);
        end
        if (v[d] && ready[d]) begin
          chk("core", 32'(core[d]), 32'(q_core[idx]));
          chk("addr", 32'(addr[d]), 32'(q_addr[idx]));
          chk("data", data[d], 32'(q_data[idx]));
          idx++;
        end
        stalled = v[d] && !ready[d];
        h_core = core[d]; h_addr = addr[d]; h_data = data[d];
      end
    end
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL timeout: instance %0d accepted %0d of %0d writes", d, idx, n);
    end
    // DONE must persist with no further writes
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("done_stay", 32'(done[d]), 32'd1);
      chk("idle_valid", 32'(v[d]), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; mode_s[d] = 1'b0; ready[d] = 1'b0;
    end

    // Reset state
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", 32'(v[d]), 32'd0);
      chk("rst_busy", 32'(busy[d]), 32'd0);
      chk("rst_done", 32'(done[d]), 32'd0);
      chk("rst_addr", 32'(addr[d]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_valid", 32'(v[0]), 32'd0);
    chk("idle_done", 32'(done[0]), 32'd0);

    // Directed table: 2 cores, mode 1, two stall cycles on core1/0x3
    tbl[0]  = mk(1, 1, 0, 1, 1, 1, 0);
    tbl[1]  = mk(1, 1, 0, 2, 0, 1, 0);
    tbl[2]  = mk(1, 1, 0, 3, 0, 1, 0);
    tbl[3]  = mk(1, 1, 0, 4, 1, 1, 0);
    tbl[4]  = mk(1, 1, 0, 5, 0, 1, 0);
    tbl[5]  = mk(1, 1, 0, 6, 1, 1, 0);
    tbl[6]  = mk(1, 1, 1, 1, 1, 1, 0);
    tbl[7]  = mk(1, 1, 1, 2, 1, 1, 0);
    tbl[8]  = mk(0, 1, 1, 3, 2, 1, 0);
    tbl[9]  = mk(0, 1, 1, 3, 2, 1, 0);
    tbl[10] = mk(1, 1, 1, 3, 2, 1, 0);
    tbl[11] = mk(1, 1, 1, 4, 3, 1, 0);
    tbl[12] = mk(1, 1, 1, 5, 1, 1, 0);
    tbl[13] = mk(1, 1, 1, 6, 1, 1, 0);
    tbl[14] = mk(1, 1, 0, 1, 0, 1, 0);
    tbl[15] = mk(1, 1, 1, 1, 0, 1, 0);
    tbl[16] = mk(1, 0, 0, 0, 0, 0, 1);
    mode_s[0] = 1'b1;
    start[0]  = 1'b1;
    ready[0]  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      start[0] = 1'b0;
      ready[0] = tbl[i].rdy;
      chk($sformatf("tbl%0d_valid", i), 32'(v[0]), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_busy", i), 32'(busy[0]), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i), 32'(done[0]), 32'(tbl[i].done));
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_core", i), 32'(core[0]), 32'(tbl[i].core));
        chk($sformatf("tbl%0d_addr", i), 32'(addr[0]), 32'(tbl[i].addr));
        chk($sformatf("tbl%0d_data", i), data[0], tbl[i].data);
      end
    end

    // Restart from DONE, ready high: done exactly 15 cycles after start
    run_seq(0, 2, 1'b1, 0, 1'b0, 1'b0, 1'b1, -1);
    // start pulsed while busy is ignored
    run_seq(0, 2, 1'b1, 0, 1'b0, 1'b1, 1'b1, -1);
    // mode flipped after start has no effect, then restart with mode 1
    run_seq(0, 2, 1'b0, 0, 1'b1, 1'b0, 1'b1, -1);
    run_seq(0, 2, 1'b1, 0, 1'b0, 1'b0, 1'b1, -1);
    // single core: 7 writes, done at t+8
    run_seq(1, 1, 1'b0, 0, 1'b0, 1'b0, 1'b1, -1);

    // Asynchronous reset between edges while presenting core1 unfreeze
    run_seq(0, 2, 1'b1, 0, 1'b0, 1'b0, 1'b0, 13);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(v[0]), 32'd0);
    chk("arst_busy", 32'(busy[0]), 32'd0);
    chk("arst_done", 32'(done[0]), 32'd0);
    chk("arst_core", 32'(core[0]), 32'd0);
    chk("arst_addr", 32'(addr[0]), 32'd0);
    chk("arst_data", data[0], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(v[0]), 32'd0);
    chk("post_rst_done", 32'(done[0]), 32'd0);
    run_seq(0, 2, 1'b0, 0, 1'b0, 1'b0, 1'b1, -1);

    // Random ready stalls and modes on both instances
    for (int it = 0; it < 8; it++) begin
      int d;
      int pct;
      d   = it % 2;
      pct = int'($urandom_range(60));
      run_seq(d, 2 - d, 1'($urandom_range(1)), pct, 1'($urandom_range(1)),
              1'($urandom_range(1)), pct == 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
